// File: rtl/uart_mmio_bridge.sv
// UART memory-mapped I/O bridge: decodes the 0x8xxx_xxxx window, buffers UART
// RX/TX bytes in two small FIFOs and exposes a free-running cycle counter.
module uart_mmio_bridge #(
   parameter int DEPTH      = 8,
   parameter int LOG2_DEPTH = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] io_addr,
   input  logic [3:0]  io_we,
   input  logic        io_re,
   input  logic [31:0] io_din,
   output logic [31:0] io_dout,
   input  logic        stall,
   output logic [7:0]  DataIn,
   output logic        DataInValid,
   input  logic        DataInReady,
   input  logic [7:0]  DataOut,
   input  logic        DataOutValid,
   output logic        DataOutReady
);
   localparam int PTR_W = LOG2_DEPTH + 1;

   localparam logic [7:0] OFF_STATUS  = 8'h00;
   localparam logic [7:0] OFF_RX_DATA = 8'h04;
   localparam logic [7:0] OFF_TX_DATA = 8'h08;
   localparam logic [7:0] OFF_CYCLES  = 8'h10;
   localparam logic [7:0] OFF_CYC_RST = 8'h18;

   logic [7:0]       rx_mem [DEPTH];
   logic [7:0]       tx_mem [DEPTH];
   logic [PTR_W-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
   logic             tx_ovf;
   logic [31:0]      cyc_cnt;

   logic        hit, rd_hit, wr_hit;
   logic [7:0]  offset;
   logic        rx_empty, rx_full, tx_empty, tx_full;
   logic        rx_push, rx_pop, tx_push_req, tx_push, tx_pop;
   logic        ovf_set, ovf_clr, cyc_clr;
   logic [7:0]  rx_head, tx_head;
   logic [31:0] rd_data;
   logic        unused_bits;

   // The extra pointer MSB distinguishes a full FIFO from an empty one.
   function automatic logic ptr_full(input logic [PTR_W-1:0] wr, input logic [PTR_W-1:0] rd);
      return (wr[PTR_W-1] != rd[PTR_W-1]) && (wr[PTR_W-2:0] == rd[PTR_W-2:0]);
   endfunction

   assign hit    = (io_addr[31:28] == 4'h8) && !stall;
   assign offset = io_addr[7:0];
   assign rd_hit = hit && io_re;
   assign wr_hit = hit && (|io_we);

   assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
   assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
   assign rx_full  = ptr_full(rx_wr_ptr, rx_rd_ptr);
   assign tx_full  = ptr_full(tx_wr_ptr, tx_rd_ptr);

   assign rx_head = rx_mem[rx_rd_ptr[LOG2_DEPTH-1:0]];
   assign tx_head = tx_mem[tx_rd_ptr[LOG2_DEPTH-1:0]];

   assign DataOutReady = !rx_full;
   assign DataInValid  = !tx_empty;
   assign DataIn       = tx_empty ? 8'd0 : tx_head;

   assign rx_push     = DataOutValid && !rx_full;
   assign rx_pop      = rd_hit && (offset == OFF_RX_DATA) && !rx_empty;
   assign tx_pop      = !tx_empty && DataInReady;
   assign tx_push_req = hit && (offset == OFF_TX_DATA) && io_we[0];
   // A same-cycle drain frees the slot, so a push at full is still accepted.
   assign tx_push     = tx_push_req && (!tx_full || tx_pop);
   assign ovf_set     = tx_push_req && tx_full && !tx_pop;
   assign ovf_clr     = wr_hit && (offset == OFF_STATUS) && io_din[2];
   assign cyc_clr     = wr_hit && (offset == OFF_CYC_RST);

   assign unused_bits = ^{io_addr[27:8], io_din[31:8]};

   always_comb begin
      rd_data = 32'd0;
      case (offset)
         OFF_STATUS:  rd_data = {29'd0, tx_ovf, !rx_empty, !tx_full};
         OFF_RX_DATA: rd_data = rx_empty ? 32'd0 : {24'd0, rx_head};
         OFF_CYCLES:  rd_data = cyc_cnt;
         default:     rd_data = 32'd0;
      endcase
   end

   // ---- stage p0 -> p1: FIFO storage, pointers, flags, read register ----
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wr_ptr[LOG2_DEPTH-1:0]] <= DataOut;
      if (tx_push) tx_mem[tx_wr_ptr[LOG2_DEPTH-1:0]] <= io_din[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_ovf    <= 1'b0;
         cyc_cnt   <= 32'd0;
         io_dout   <= 32'd0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
         if (ovf_set)      tx_ovf <= 1'b1;
         else if (ovf_clr) tx_ovf <= 1'b0;
         cyc_cnt <= cyc_clr ? 32'd0 : cyc_cnt + 32'd1;
         if (rd_hit) io_dout <= rd_data;
      end
   end
endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed self-checking bench for uart_mmio_bridge.
module tb_uart_mmio_bridge;
   localparam logic [31:0] A_STATUS  = 32'h8000_0000;
   localparam logic [31:0] A_RX_DATA = 32'h8000_0004;
   localparam logic [31:0] A_TX_DATA = 32'h8000_0008;
   localparam logic [31:0] A_CYCLES  = 32'h8000_0010;
   localparam logic [31:0] A_CYC_RST = 32'h8000_0018;

   logic        clk, rst;
   logic [31:0] io_addr, io_din, io_dout;
   logic [3:0]  io_we;
   logic        io_re, stall;
   logic [7:0]  DataIn, DataOut;
   logic        DataInValid, DataInReady, DataOutValid, DataOutReady;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] r2, r3;

   uart_mmio_bridge #(.DEPTH(8), .LOG2_DEPTH(3)) dut (
      .clk(clk), .rst(rst), .io_addr(io_addr), .io_we(io_we), .io_re(io_re),
      .io_din(io_din), .io_dout(io_dout), .stall(stall),
      .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
      .DataOut(DataOut), .DataOutValid(DataOutValid), .DataOutReady(DataOutReady)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rd(input logic [31:0] addr);
      io_addr = addr;
      io_re   = 1'b1;
      io_we   = 4'b0000;
      tick();
      io_re   = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
      io_addr = addr;
      io_din  = data;
      io_we   = we;
      io_re   = 1'b0;
      tick();
      io_we   = 4'b0000;
   endtask

   initial begin
      rst = 1'b1; io_addr = 32'd0; io_din = 32'd0; io_we = 4'd0; io_re = 1'b0;
      stall = 1'b0; DataInReady = 1'b0; DataOut = 8'd0; DataOutValid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check("rst_dout", io_dout, 32'h0);
      check("rst_txvalid", {31'd0, DataInValid}, 32'h0);
      check("rst_datain", {24'd0, DataIn}, 32'h0);
      check("rst_rxready", {31'd0, DataOutReady}, 32'h1);
      rd(A_STATUS);
      check("status_idle", io_dout, 32'h1);

      // single RX byte
      DataOut = 8'h7a; DataOutValid = 1'b1;
      tick();
      DataOutValid = 1'b0;
      rd(A_STATUS);   check("status_rx1", io_dout, 32'h3);
      rd(A_RX_DATA);  check("rx_7a", io_dout, 32'h7a);
      rd(A_STATUS);   check("status_rx0", io_dout, 32'h1);

      // TX fill and overflow
      for (int i = 0; i < 8; i++) wr(A_TX_DATA, 32'h41 + i, 4'b0001);
      rd(A_STATUS);   check("status_txfull", io_dout, 32'h0);
      wr(A_TX_DATA, 32'h49, 4'b0001);
      rd(A_STATUS);   check("status_ovf", io_dout, 32'h4);
      check("tx_head", {24'd0, DataIn}, 32'h41);
      DataInReady = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("tx_drain", {23'd0, DataInValid, DataIn}, 32'h100 + 32'h41 + i);
         tick();
      end
      DataInReady = 1'b0;
      check("tx_drained", {31'd0, DataInValid}, 32'h0);
      wr(A_STATUS, 32'h4, 4'b1111);
      rd(A_STATUS);   check("status_ovf_clr", io_dout, 32'h1);

      // RX full, then push+pop across the pointer wrap
      DataOutValid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         DataOut = 8'(8'hA0 + i);
         tick();
      end
      check("rx_full_ready", {31'd0, DataOutReady}, 32'h0);
      DataOut = 8'hA8;
      rd(A_RX_DATA);  check("rx_pop_full", io_dout, 32'hA0);
      check("rx_ready_7", {31'd0, DataOutReady}, 32'h1);
      rd(A_RX_DATA);  check("rx_pushpop", io_dout, 32'hA1);
      check("rx_ready_pp", {31'd0, DataOutReady}, 32'h1);
      DataOutValid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         rd(A_RX_DATA);
         check("rx_order", io_dout, 32'hA2 + i);
      end
      rd(A_RX_DATA);  check("rx_empty_rd", io_dout, 32'h0);

      // stall and out-of-window accesses have no effect
      DataOut = 8'h5c; DataOutValid = 1'b1;
      tick();
      DataOutValid = 1'b0;
      rd(A_STATUS);   check("status_rx_again", io_dout, 32'h3);
      stall = 1'b1;
      rd(A_RX_DATA);  check("stall_hold", io_dout, 32'h3);
      stall = 1'b0;
      rd(32'h0000_0004); check("miss_hold", io_dout, 32'h3);
      wr(32'h0000_0008, 32'h99, 4'b0001);
      check("miss_no_tx", {31'd0, DataInValid}, 32'h0);
      rd(A_RX_DATA);  check("stall_no_pop", io_dout, 32'h5c);
      rd(A_RX_DATA);  check("rx_empty2", io_dout, 32'h0);
      rd(A_STATUS);   check("status_after_empty", io_dout, 32'h1);
      rd(32'h8000_000C); check("unmapped_rd", io_dout, 32'h0);

      // cycle counter: clear, count, wrap
      wr(A_CYC_RST, 32'h0, 4'b1000);
      for (int i = 0; i < 9; i++) tick();
      rd(A_CYCLES);   check("cycles_10", io_dout, 32'd9);
      force dut.cyc_cnt = 32'hFFFF_FFFF;
      tick();
      release dut.cyc_cnt;
      rd(A_CYCLES);   r2 = io_dout;
      rd(A_CYCLES);   r3 = io_dout;
      check("cycles_wrap_zero", {31'd0, (r2 == 32'd0) || (r3 == 32'd0)}, 32'h1);
      check("cycles_wrap_step", r3 - r2, 32'd1);

      // TX push+pop at full does not overflow
      for (int i = 0; i < 8; i++) wr(A_TX_DATA, 32'h60 + i, 4'b0001);
      DataInReady = 1'b1;
      wr(A_TX_DATA, 32'h68, 4'b0001);
      DataInReady = 1'b0;
      check("tx_pp_head", {24'd0, DataIn}, 32'h61);
      rd(A_STATUS);   check("tx_pp_no_ovf", io_dout, 32'h0);

      // reset in the middle of a drain
      DataInReady = 1'b1;
      tick(); tick();
      check("mid_drain", {23'd0, DataInValid, DataIn}, 32'h163);
      rst = 1'b1;
      tick();
      rst = 1'b0; DataInReady = 1'b0;
      check("rst_mid_valid", {31'd0, DataInValid}, 32'h0);
      check("rst_mid_datain", {24'd0, DataIn}, 32'h0);
      check("rst_mid_dout", io_dout, 32'h0);
      rd(A_STATUS);   check("status_post_rst", io_dout, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
